// File: rtl/mips32_program_loader.sv
// Host-side boot/debug loader for the MIPS32 pipelined core: loads Mem,
// launches the core at a PC, waits for HLT, and streams Mem back out.
module mips32_program_loader #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 4096,
    parameter int TO_W    = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              core_hold,
    output logic              core_start,
    output logic [ADDR_W-1:0] core_pc,
    input  logic              core_halted,
    output logic              busy,
    output logic              err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRD,
        S_DCAP,
        S_DOUT
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [9:0]        rem_q, rem_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       odata_q, odata_d;
    logic              ovalid_q, ovalid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              err_q, err_d;

    logic [1:0]        hdr_op;
    logic [9:0]        hdr_cnt;
    logic [ADDR_W-1:0] hdr_arg;
    logic              unused_hdr;

    assign hdr_op     = in_data[31:30];
    assign hdr_cnt    = in_data[29:20];
    assign hdr_arg    = in_data[ADDR_W-1:0];
    assign unused_hdr = ^in_data[19:ADDR_W];

    // A LOAD sits in S_LOAD with rem_q==0 for its final write cycle.
    assign in_ready = !rst && ((state_q == S_IDLE) ||
                               (state_q == S_LOAD && rem_q != 10'd0));

    assign mem_we      = we_q;
    assign mem_re      = (state_q == S_DRD);
    assign mem_addr    = (state_q == S_DRD) ? addr_q : waddr_q;
    assign mem_wdata   = wdata_q;
    assign out_data    = odata_q;
    assign out_valid   = ovalid_q;
    assign core_hold   = (state_q != S_RUN);
    assign core_start  = (state_q == S_RUN) && (to_q == '0);
    assign core_pc     = pc_q;
    assign busy        = (state_q != S_IDLE);
    assign err_timeout = err_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        to_d     = to_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        odata_d  = odata_q;
        ovalid_d = ovalid_q;
        pc_d     = pc_q;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    unique case (hdr_op)
                        2'b01: begin
                            if (hdr_cnt != 10'd0) begin
                                addr_d  = hdr_arg;
                                rem_d   = hdr_cnt;
                                state_d = S_LOAD;
                            end
                        end
                        2'b10: begin
                            pc_d    = hdr_arg;
                            err_d   = 1'b0;
                            to_d    = '0;
                            state_d = S_RUN;
                        end
                        2'b11: begin
                            if (hdr_cnt != 10'd0) begin
                                addr_d  = hdr_arg;
                                rem_d   = hdr_cnt;
                                state_d = S_DRD;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_LOAD: begin
                if (rem_q == 10'd0) begin
                    state_d = S_IDLE;
                end else if (in_valid) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = in_data;
                    addr_d  = addr_q + 1'b1;
                    rem_d   = rem_q - 10'd1;
                end
            end
            S_RUN: begin
                to_d = to_q + 1'b1;
                // Halt beats timeout; the first cycle's HALTED is stale.
                if (to_q != '0 && core_halted) begin
                    state_d = S_IDLE;
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DRD: state_d = S_DCAP;
            S_DCAP: begin
                odata_d  = mem_rdata;
                ovalid_d = 1'b1;
                state_d  = S_DOUT;
            end
            S_DOUT: begin
                if (out_ready) begin
                    ovalid_d = 1'b0;
                    addr_d   = addr_q + 1'b1;
                    rem_d    = rem_q - 10'd1;
                    state_d  = (rem_q == 10'd1) ? S_IDLE : S_DRD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            to_q     <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            pc_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            to_q     <= to_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            pc_q     <= pc_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: doc/mips32_program_loader.md
Name: mips32_program_loader

Overview:
- Host-side boot/debug controller sitting directly upstream of MIPS32_pipelined_risc.
- Accepts a 32-bit command stream from the host and writes programs and data into the core's unified Mem array through a write port.
- Holds the core quiescent during loading, launches it at a given PC, and waits for HLT.
- Streams a window of Mem back to the host, so directed programs run without hierarchical preloads.

Parameters:
- ADDR_W, 10, Mem word-address width (1024 words).
- TIMEOUT, 4096, max cycles RUN waits for core_halted before flagging an error.
- TO_W, 13, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_data  in  32  command/data word from host.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts in_data this cycle.
- out_data  out  32  Mem readback word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  host accepts out_data.
- mem_we  out  1  Mem write strobe.
- mem_re  out  1  Mem read strobe; data returns one cycle later.
- mem_addr  out  ADDR_W  Mem word address.
- mem_wdata  out  32  Mem write data.
- mem_rdata  in  32  Mem read data (1-cycle latency after mem_re).
- core_hold  out  1  forces the core halted with no PC update; high except during RUN.
- core_start  out  1  one-cycle pulse; the core loads PC from core_pc, clears HALTED and TAKEN_BRANCH.
- core_pc  out  ADDR_W  start PC.
- core_halted  in  1  core HALTED flag.
- busy  out  1  FSM not in IDLE.
- err_timeout  out  1  sticky; last RUN timed out.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, core_hold=1, core_start=0, core_pc=0, busy=0, err_timeout=0. FSM enters IDLE.
- A transfer occurs on any cycle with valid&&ready. Data and valid are held stable until the transfer.
- Header decode in IDLE: op=in_data[31:30], cnt=in_data[29:20] (10 bits), arg=in_data[ADDR_W-1:0].
  - op 00 NOP: consumed, no action.
  - op 01 LOAD: go to LOAD_DATA with addr=arg, remaining=cnt. If cnt=0, stay in IDLE.
  - op 10 RUN: core_pc<=arg, err_timeout<=0, go to RUN.
  - op 11 DUMP: addr=arg, remaining=cnt. If cnt=0, stay in IDLE; else go to DUMP_RD.
- States:
  - IDLE: in_ready=1.
  - LOAD_DATA: in_ready=1. On each transfer, in the next cycle mem_we=1, mem_addr=addr, mem_wdata=in_data; then addr++, remaining--. After the last word's write cycle, return to IDLE. Back-to-back words allowed; one write per accepted word, in order.
  - RUN: core_hold=0. core_start pulses high for exactly the first cycle in RUN. core_halted is ignored in that cycle and sampled from the 2nd cycle on. A timeout counter starts at 0 and increments each cycle.
    - core_halted=1 → IDLE, core_hold=1 next cycle.
    - Counter reaches TIMEOUT without halt → err_timeout=1, core_hold=1, IDLE.
    - in_ready=0 throughout RUN.
  - DUMP_RD: mem_re=1 with mem_addr=addr for one cycle, then DUMP_CAP.
  - DUMP_CAP: latch mem_rdata into out_data, out_valid=1, go to DUMP_OUT.
  - DUMP_OUT: hold out_data/out_valid until out_ready. On transfer: out_valid=0, addr++, remaining--. If remaining now 0 → IDLE, else DUMP_RD. Throughput is one word per 3 cycles; this is acceptable.
- Arithmetic: addr increments modulo 2^ADDR_W, so base+cnt crossing the top wraps to 0. remaining is 10-bit unsigned.
- Exclusivity: mem_we and mem_re are never both high. Neither is high during RUN, because the core owns Mem then.
- Simultaneous events: core_halted and timeout in the same cycle → halt wins, err_timeout=0.
- Reset mid-operation returns to IDLE with reset values and core_hold=1. Partially loaded words remain in Mem. A pending out word is dropped.
- busy=1 in every state except IDLE.

Test Plan:
- LOAD base 0, cnt 8 with words 28010078, 0c631800, 20220000, 0c631800, 2842002d, 0c631800, 24220001, fc000000 → exactly 8 mem_we pulses at addrs 0..7 with matching data; in_ready stays high; busy falls after the 8th write.
- LOAD base 120, cnt 1, word 85; then RUN pc 0 with the core model → core_start single pulse, core_pc=0, core_hold low until core_halted, err_timeout=0.
- DUMP base 120, cnt 2 with out_ready toggling 1010 → out words 85 then 130 in order; out_data stable while out_valid&&!out_ready.
- LOAD base 1022, cnt 4 → writes at 1022, 1023, 0, 1 (wrap).
- RUN with core_halted tied 0, TIMEOUT=16 → err_timeout=1 after 16 counted cycles, core_hold=1; a following RUN clears err_timeout.
- Assert rst during the 3rd word of a cnt-8 LOAD → next cycle all outputs at reset values, FSM IDLE; the next header is decoded normally; NOP and cnt=0 headers produce no mem strobes.
